sound_latch_c1: RTL and testbench

Sound-command mailbox between the 68000 and the Z80, the NEO-C1 side of the sound interface. Latches the 68k command byte and pulses `nSDW` to request a Z80 NMI. Serves the command to the Z80 on port reads and latches the Z80's reply byte for the 68k. Acts on the `nSDZ80R` / `nSDZ80W` / `nSDZ80CLR` port decodes from the Z80 control block, and drives the `nSDW` that block consumes.

---
 rtl/sound_latch_c1.sv | 117 +++++++++++
 tb/tb_sound_latch_c1.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sound_latch_c1.sv
// 68000 <-> Z80 sound-command mailbox (NEO-C1 side): latches the command byte,
// pulses nSDW to request a Z80 NMI, and latches the Z80 reply for the 68k.
module sound_latch_c1 #(
    parameter int NSDW_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] M68K_DIN,
    input  logic       nSOUND_WR,
    input  logic       nSOUND_RD,
    output logic [7:0] M68K_DOUT,
    input  logic [7:0] SDD_IN,
    output logic [7:0] SDD_OUT,
    output logic       SDD_OE,
    input  logic       nSDZ80R,
    input  logic       nSDZ80W,
    input  logic       nSDZ80CLR,
    output logic       nSDW,
    output logic       CMD_PENDING,
    output logic       REPLY_PENDING,
    output logic       CMD_OVERRUN
);

    localparam logic [7:0] PULSE_LEN = 8'(NSDW_CYCLES);

    logic       soundWrPrev, soundRdPrev, z80RdPrev, z80WrPrev, z80ClrPrev;
    logic       soundWrFall, soundRdFall, z80RdFall, z80WrRise, z80ClrFall;
    logic [7:0] cmd, reply, sample, pulseCnt;
    logic       nSdwReg, cmdPending, replyPending, cmdOverrun;

    // Strobes are levels; each one yields a single event on its first sampled edge.
    assign soundWrFall = ~nSOUND_WR & soundWrPrev;
    assign soundRdFall = ~nSOUND_RD & soundRdPrev;
    assign z80RdFall   = ~nSDZ80R   & z80RdPrev;
    assign z80ClrFall  = ~nSDZ80CLR & z80ClrPrev;
    assign z80WrRise   =  nSDZ80W   & ~z80WrPrev;

    // NOTE: state registers use non-blocking assignments so every block reads pre-edge values.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            soundWrPrev <= 1'b1;
            soundRdPrev <= 1'b1;
            z80RdPrev   <= 1'b1;
            z80WrPrev   <= 1'b1;
            z80ClrPrev  <= 1'b1;
        end else begin
            soundWrPrev <= nSOUND_WR;
            soundRdPrev <= nSOUND_RD;
            z80RdPrev   <= nSDZ80R;
            z80WrPrev   <= nSDZ80W;
            z80ClrPrev  <= nSDZ80CLR;
        end
    end

    // A 68k write wins over a same-edge Z80 clear or read; overrun looks at the old pending bit.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cmd        <= 8'h00;
            cmdPending <= 1'b0;
            cmdOverrun <= 1'b0;
        end else if (soundWrFall) begin
            cmd        <= M68K_DIN;
            cmdPending <= 1'b1;
            if (cmdPending)
                cmdOverrun <= 1'b1;
            else if (z80ClrFall)
                cmdOverrun <= 1'b0;
        end else if (z80ClrFall) begin
            cmd        <= 8'h00;
            cmdPending <= 1'b0;
            cmdOverrun <= 1'b0;
        end else if (z80RdFall) begin
            cmdPending <= 1'b0;
        end
    end

    // A write during a pulse reloads the counter, stretching nSDW without a gap.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pulseCnt <= 8'h00;
            nSdwReg  <= 1'b1;
        end else if (soundWrFall) begin
            pulseCnt <= PULSE_LEN;
            nSdwReg  <= 1'b0;
        end else if (pulseCnt != 8'h00) begin
            pulseCnt <= pulseCnt - 8'h01;
            if (pulseCnt == 8'h01)
                nSdwReg <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sample       <= 8'h00;
            reply        <= 8'h00;
            replyPending <= 1'b0;
        end else begin
            if (!nSDZ80W)
                sample <= SDD_IN;
            if (z80WrRise) begin
                reply        <= sample;
                replyPending <= 1'b1;
            end else if (soundRdFall) begin
                replyPending <= 1'b0;
            end
        end
    end

    assign SDD_OUT       = cmd;
    assign SDD_OE        = ~nSDZ80R & nRESET;
    assign M68K_DOUT     = reply;
    assign nSDW          = nSdwReg;
    assign CMD_PENDING   = cmdPending;
    assign REPLY_PENDING = replyPending;
    assign CMD_OVERRUN   = cmdOverrun;

endmodule

// File: tb/tb_sound_latch_c1.sv
// Directed bench for sound_latch_c1: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_sound_latch_c1;

    typedef enum int { S_NSDW, S_OE, S_SDDOUT, S_DOUT, S_CMDP, S_REPP, S_OVR } sig_e;
    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic [7:0] M68K_DIN, M68K_DOUT, SDD_IN, SDD_OUT;
    logic       nSOUND_WR, nSOUND_RD, SDD_OE, nSDZ80R, nSDZ80W, nSDZ80CLR;
    logic       nSDW, CMD_PENDING, REPLY_PENDING, CMD_OVERRUN;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    sound_latch_c1 #(.NSDW_CYCLES(4)) dut (
        .CLK(CLK), .nRESET(nRESET),
        .M68K_DIN(M68K_DIN), .nSOUND_WR(nSOUND_WR), .nSOUND_RD(nSOUND_RD),
        .M68K_DOUT(M68K_DOUT), .SDD_IN(SDD_IN), .SDD_OUT(SDD_OUT), .SDD_OE(SDD_OE),
        .nSDZ80R(nSDZ80R), .nSDZ80W(nSDZ80W), .nSDZ80CLR(nSDZ80CLR),
        .nSDW(nSDW), .CMD_PENDING(CMD_PENDING), .REPLY_PENDING(REPLY_PENDING),
        .CMD_OVERRUN(CMD_OVERRUN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] actual(sig_e s);
        case (s)
            S_NSDW:   return {7'd0, nSDW};
            S_OE:     return {7'd0, SDD_OE};
            S_SDDOUT: return SDD_OUT;
            S_DOUT:   return M68K_DOUT;
            S_CMDP:   return {7'd0, CMD_PENDING};
            S_REPP:   return {7'd0, REPLY_PENDING};
            default:  return {7'd0, CMD_OVERRUN};
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [7:0] got;
        got = actual(e.sig);
        total++;
        if (got !== e.val) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %02h expected %02h", e.name, e.cyc, got, e.val);
        end
    endtask

    // Monitor: state after posedge N is compared at the following negedge.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: expectation for cyc %0d not reached in time", e.name, e.cyc);
            end else begin
                check(e);
            end
        end
    end

    task automatic expect_at(input string name, input sig_e s, input logic [7:0] v, input int off);
        exp_t e;
        int   i;
        e.cyc  = cyc + off;
        e.sig  = s;
        e.val  = v;
        e.name = name;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
        sb.insert(i, e);
    endtask

    task automatic expect_range(input string name, input sig_e s, input logic [7:0] v,
                                input int from_off, input int to_off);
        for (int k = from_off; k <= to_off; k++) expect_at(name, s, v, k);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        nRESET = 1'b0; M68K_DIN = 8'h00; SDD_IN = 8'h00;
        nSOUND_WR = 1'b1; nSOUND_RD = 1'b1; nSDZ80R = 1'b1; nSDZ80W = 1'b1; nSDZ80CLR = 1'b1;
        step();
        expect_at("rst_nsdw", S_NSDW, 8'h01, 0);
        expect_at("rst_oe", S_OE, 8'h00, 0);
        expect_at("rst_dout", S_DOUT, 8'h00, 0);
        expect_at("rst_cmdp", S_CMDP, 8'h00, 0);
        expect_at("rst_repp", S_REPP, 8'h00, 0);
        expect_at("rst_ovr", S_OVR, 8'h00, 0);
        step();
        nRESET = 1'b1;
        step(2);

        // Single write of $A5, strobe held 3 cycles: one 4-cycle pulse.
        M68K_DIN = 8'hA5; nSOUND_WR = 1'b0;
        expect_at("a5_nsdw_pre", S_NSDW, 8'h01, 0);
        expect_range("a5_nsdw_low", S_NSDW, 8'h00, 1, 4);
        expect_range("a5_nsdw_end", S_NSDW, 8'h01, 5, 7);
        expect_at("a5_cmdp", S_CMDP, 8'h01, 1);
        expect_at("a5_sddout", S_SDDOUT, 8'hA5, 1);
        expect_at("a5_ovr", S_OVR, 8'h00, 1);
        step(3);
        nSOUND_WR = 1'b1;
        step(5);
        nSDZ80R = 1'b0;
        expect_at("a5_oe", S_OE, 8'h01, 0);
        expect_at("a5_rd_sddout", S_SDDOUT, 8'hA5, 0);
        expect_at("a5_rd_cmdp_hold", S_CMDP, 8'h01, 0);
        expect_at("a5_rd_cmdp_clr", S_CMDP, 8'h00, 1);
        step(2);
        nSDZ80R = 1'b1;
        expect_at("a5_oe_off", S_OE, 8'h00, 0);
        step(2);

        // Back-to-back writes $11 / $22: stretched 6-cycle pulse and overrun.
        M68K_DIN = 8'h11; nSOUND_WR = 1'b0;
        expect_range("ovr_nsdw_low", S_NSDW, 8'h00, 1, 6);
        expect_at("ovr_nsdw_end", S_NSDW, 8'h01, 7);
        expect_at("ovr_flag_pre", S_OVR, 8'h00, 2);
        expect_at("ovr_flag", S_OVR, 8'h01, 3);
        expect_at("ovr_sddout", S_SDDOUT, 8'h22, 3);
        step();
        nSOUND_WR = 1'b1;
        step();
        M68K_DIN = 8'h22; nSOUND_WR = 1'b0;
        step();
        nSOUND_WR = 1'b1;
        step(5);
        nSDZ80CLR = 1'b0;
        expect_at("clr_ovr_pre", S_OVR, 8'h01, 0);
        expect_at("clr_sddout", S_SDDOUT, 8'h00, 1);
        expect_at("clr_cmdp", S_CMDP, 8'h00, 1);
        expect_at("clr_ovr", S_OVR, 8'h00, 1);
        step();
        nSDZ80CLR = 1'b1;
        step(2);

        // Reply: Z80 writes $3C, $3C, $C3; the last one is latched on the rise.
        nSDZ80W = 1'b0; SDD_IN = 8'h3C;
        step(2);
        SDD_IN = 8'hC3;
        step();
        nSDZ80W = 1'b1; SDD_IN = 8'hFF;
        expect_at("rep_dout_pre", S_DOUT, 8'h00, 0);
        expect_at("rep_repp_pre", S_REPP, 8'h00, 0);
        expect_at("rep_dout", S_DOUT, 8'hC3, 1);
        expect_at("rep_repp", S_REPP, 8'h01, 1);
        step(3);
        nSOUND_RD = 1'b0;
        expect_at("rd_repp_hold", S_REPP, 8'h01, 0);
        expect_at("rd_repp_clr", S_REPP, 8'h00, 1);
        expect_at("rd_dout_keep", S_DOUT, 8'hC3, 1);
        step(2);
        nSOUND_RD = 1'b1;
        step();

        // Z80 write rise and 68k read fall on the same edge: pending stays set.
        nSDZ80W = 1'b0; SDD_IN = 8'h5A;
        step();
        nSDZ80W = 1'b1; nSOUND_RD = 1'b0;
        expect_at("prio_dout", S_DOUT, 8'h5A, 1);
        expect_at("prio_repp", S_REPP, 8'h01, 1);
        step();
        nSOUND_RD = 1'b1;
        step(2);

        // 68k write of $77 and Z80 clear on the same edge: the write wins.
        M68K_DIN = 8'h77; nSOUND_WR = 1'b0; nSDZ80CLR = 1'b0;
        expect_at("wclr_sddout", S_SDDOUT, 8'h77, 1);
        expect_at("wclr_cmdp", S_CMDP, 8'h01, 1);
        expect_at("wclr_nsdw", S_NSDW, 8'h00, 1);
        expect_at("wclr_ovr", S_OVR, 8'h00, 1);
        step();
        nSOUND_WR = 1'b1; nSDZ80CLR = 1'b1;
        step(6);

        // Reset asserted in the 2nd cycle of a pulse: nSDW returns high at once and stays high.
        M68K_DIN = 8'h99; nSOUND_WR = 1'b0;
        expect_at("mid_nsdw_low", S_NSDW, 8'h00, 1);
        step();
        nSOUND_WR = 1'b1;
        step();
        nRESET = 1'b0;
        expect_at("mid_rst_nsdw", S_NSDW, 8'h01, 0);
        expect_at("mid_rst_cmdp", S_CMDP, 8'h00, 0);
        expect_at("mid_rst_sddout", S_SDDOUT, 8'h00, 0);
        step();
        nRESET = 1'b1;
        expect_range("mid_post_nsdw", S_NSDW, 8'h01, 0, 5);
        expect_at("mid_post_dout", S_DOUT, 8'h00, 1);
        step(6);

        for (int w = 0; w < 20 && sb.size() > 0; w++) step();
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
